// File: rtl/stereo_job_sequencer.sv
// Frame-level job sequencer: for each Trigger, runs one worker job per channel in
// order, watching for completion (end pulse or busy falling edge), with a per-job
// timeout watchdog and an abort path. Reports Done/Error/Overrun and a good-frame count.
module stereo_job_sequencer #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CHW     = 1,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TOW     = 11
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Trigger,
  input  logic           Abort,
  output logic           WorkStart,
  output logic [CHW-1:0] WorkCh,
  input  logic           WorkBusy,
  input  logic           WorkEnd,
  output logic           Busy,
  output logic           Done,
  output logic           Error,
  output logic [CHW-1:0] ErrCh,
  output logic           Overrun,
  output logic [15:0]    FrameCnt
);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StNext, StFinish} state_e;

  localparam logic [CHW-1:0] LastCh  = CHW'(NUM_CH - 1);
  localparam logic [TOW-1:0] TmoLast = TOW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TOW-1:0] tmo_q, tmo_d;
  logic           seen_busy_q, seen_busy_d;
  logic           work_busy_q;
  logic           error_q, error_d;
  logic [CHW-1:0] err_ch_q, err_ch_d;
  logic           overrun_q;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           complete;

  // A busy fall only counts once busy has been seen high during this job's wait,
  // so a level left over from the previous job cannot complete the new one.
  assign complete = WorkEnd | (work_busy_q & ~WorkBusy & seen_busy_q);

  // Next-state, datapath updates and strobe outputs.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    tmo_d       = tmo_q;
    seen_busy_d = seen_busy_q;
    error_d     = error_q;
    err_ch_d    = err_ch_q;
    frame_cnt_d = frame_cnt_q;
    WorkStart   = 1'b0;
    Done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Trigger) begin
          error_d  = 1'b0;
          err_ch_d = '0;
          ch_d     = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (Abort) begin
          error_d  = 1'b1;
          err_ch_d = ch_q;
          state_d  = StFinish;
        end else begin
          WorkStart   = 1'b1;
          tmo_d       = '0;
          seen_busy_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        seen_busy_d = seen_busy_q | WorkBusy;
        if (Abort) begin
          error_d  = 1'b1;
          err_ch_d = ch_q;
          state_d  = StFinish;
        end else if (complete) begin
          state_d = StNext;
        end else if (tmo_q == TmoLast) begin
          // Watchdog expiry abandons the rest of the frame.
          error_d  = 1'b1;
          err_ch_d = ch_q;
          state_d  = StFinish;
        end else begin
          tmo_d = tmo_q + TOW'(1);
        end
      end
      StNext: begin
        if (Abort) begin
          error_d  = 1'b1;
          err_ch_d = ch_q;
          state_d  = StFinish;
        end else if (ch_q == LastCh) begin
          state_d = StFinish;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = StStart;
        end
      end
      StFinish: begin
        Done = 1'b1;
        if (!error_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      tmo_q       <= '0;
      seen_busy_q <= 1'b0;
      work_busy_q <= 1'b0;
      error_q     <= 1'b0;
      err_ch_q    <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      tmo_q       <= tmo_d;
      seen_busy_q <= seen_busy_d;
      work_busy_q <= WorkBusy;
      error_q     <= error_d;
      err_ch_q    <= err_ch_d;
      overrun_q   <= Trigger & (state_q != StIdle);
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign Busy     = (state_q != StIdle);
  assign WorkCh   = ch_q;
  assign Error    = error_q;
  assign ErrCh    = err_ch_q;
  assign Overrun  = overrun_q;
  assign FrameCnt = frame_cnt_q;

endmodule

// File: tb/tb_stereo_job_sequencer.sv
// Randomized bench for stereo_job_sequencer. Each frame's outcome (start cycles,
// Done cycle, Error/ErrCh, FrameCnt, Overrun) is predicted arithmetically from the
// per-channel worker latencies, abort time and extra triggers, then compared.
module tb_stereo_job_sequencer;

  localparam int NCH    = 2;
  localparam int TMO    = 16;
  localparam int MNever = 0;
  localparam int MEnd   = 1;
  localparam int MBusy  = 2;
  localparam int MBoth  = 3;

  logic        Clock = 1'b0;
  logic        Reset, Trigger, Abort, WorkStart, WorkBusy, WorkEnd;
  logic        Busy, Done, Error, Overrun;
  logic [0:0]  WorkCh, ErrCh;
  logic [15:0] FrameCnt;

  stereo_job_sequencer #(
    .NUM_CH (NCH),
    .CHW    (1),
    .TIMEOUT(TMO),
    .TOW    (5)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Trigger  (Trigger),
    .Abort    (Abort),
    .WorkStart(WorkStart),
    .WorkCh   (WorkCh),
    .WorkBusy (WorkBusy),
    .WorkEnd  (WorkEnd),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .ErrCh    (ErrCh),
    .Overrun  (Overrun),
    .FrameCnt (FrameCnt)
  );

  always #5 Clock = ~Clock;

  int cyc;
  int sch_trig, sch_ov, sch_ov2, sch_abort;
  int fr_mode[NCH];
  int fr_d[NCH];
  int fr_e[NCH];
  bit wk_on;
  int wk_s, wk_mode, wk_d, wk_e, wk_free;
  int obs_st_cyc[$];
  int obs_st_ch[$];
  int obs_done[$];
  int obs_ov[$];
  int n_vec, n_err;
  logic [15:0] fcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycles from WorkStart to the WAIT cycle where completion is visible.
  function automatic int lat_of(input int m, input int d, input int e);
    if (m == MNever) return TMO + 1;
    if (m == MEnd) return e;
    return d + 1;
  endfunction

  // One clock: drive inputs after the rising edge, observe at the falling edge.
  task automatic cycle_step();
    @(posedge Clock);
    cyc++;
    #1;
    Trigger  = (cyc == sch_trig) || (cyc == sch_ov) || (cyc == sch_ov2);
    Abort    = (cyc == sch_abort);
    WorkBusy = wk_on && (wk_mode == MBusy || wk_mode == MBoth) &&
               cyc >= wk_s + 1 && cyc <= wk_s + wk_d;
    WorkEnd  = wk_on && ((wk_mode == MEnd && cyc == wk_s + wk_e) ||
                         (wk_mode == MBoth && cyc == wk_s + wk_d + 1));
    @(negedge Clock);
    if (WorkStart === 1'b1) begin
      obs_st_cyc.push_back(cyc);
      obs_st_ch.push_back(int'(WorkCh));
      wk_on   = 1'b1;
      wk_s    = cyc;
      wk_mode = fr_mode[WorkCh];
      wk_d    = fr_d[WorkCh];
      wk_e    = fr_e[WorkCh];
      wk_free = (wk_mode == MNever) ? cyc + 1 : cyc + lat_of(wk_mode, wk_d, wk_e) + 1;
    end
    if (Done === 1'b1) obs_done.push_back(cyc);
    if (Overrun === 1'b1) obs_ov.push_back(cyc);
  endtask

  // ab/ov/ov2 are offsets from the trigger cycle (-1 none); ov 999 means the FINISH cycle.
  task automatic run_frame(input int m0, input int m1, input int d0, input int d1,
                           input int e0, input int e1, input int ab, input int ov,
                           input int ov2, input int gap, input bit chain);
    int t, s, fin, err, errch, nst, lat, endw, ov_c, ov2_c, n_ov;
    int exp_s[NCH];
    fr_mode[0] = m0; fr_mode[1] = m1;
    fr_d[0] = d0; fr_d[1] = d1;
    fr_e[0] = e0; fr_e[1] = e1;
    t = cyc + 1 + gap;
    if (t < wk_free) t = wk_free;
    s = t + 1; fin = 0; err = 0; errch = 0; nst = 0;
    for (int k = 0; k < NCH; k++) begin
      lat  = lat_of(fr_mode[k], fr_d[k], fr_e[k]);
      endw = (lat <= TMO) ? s + lat + 1 : s + TMO;
      if (ab >= 0 && t + ab >= s && t + ab <= endw) begin
        if (t + ab != s) begin
          exp_s[nst] = s;
          nst++;
        end
        fin = t + ab + 1; err = 1; errch = k;
        break;
      end
      exp_s[nst] = s;
      nst++;
      if (lat > TMO) begin
        fin = s + TMO + 1; err = 1; errch = k;
        break;
      end
      if (k == NCH - 1) fin = s + lat + 2;
      else s = s + lat + 2;
    end
    ov_c = -1; ov2_c = -1;
    if (ov == 999) ov_c = fin;
    else if (ov >= 1) ov_c = (t + ov > fin) ? fin : t + ov;
    if (ov2 == 999) ov2_c = fin;
    else if (ov2 >= 1) ov2_c = (t + ov2 > fin) ? fin : t + ov2;
    n_ov = (ov_c >= 0 ? 1 : 0) + (ov2_c >= 0 ? 1 : 0);
    sch_trig = t;
    sch_abort = (ab >= 0) ? t + ab : -1;
    sch_ov = ov_c;
    sch_ov2 = ov2_c;
    obs_st_cyc.delete(); obs_st_ch.delete(); obs_done.delete(); obs_ov.delete();

    while (cyc < t) cycle_step();
    chk("idle_busy", Busy, 0);
    chk("fcnt_pre", FrameCnt, fcnt);
    cycle_step();
    chk("busy_on", Busy, 1);
    chk("err_clr", Error, 0);
    while (cyc < fin) cycle_step();
    chk("busy_fin", Busy, 1);
    chk("done_n", obs_done.size(), 1);
    if (obs_done.size() > 0) chk("done_cyc", obs_done[0], fin);
    chk("err", Error, err);
    chk("errch", ErrCh, errch);
    chk("start_n", obs_st_cyc.size(), nst);
    for (int i = 0; i < nst && i < obs_st_cyc.size(); i++) begin
      chk("start_cyc", obs_st_cyc[i], exp_s[i]);
      chk("start_ch", obs_st_ch[i], i);
    end
    if (err == 0) fcnt = fcnt + 16'd1;
    if (!chain) begin
      cycle_step();
      chk("busy_off", Busy, 0);
      chk("fcnt", FrameCnt, fcnt);
      chk("ov_n", obs_ov.size(), n_ov);
      if (ov_c >= 0 && obs_ov.size() > 0) chk("ov_cyc", obs_ov[0], ov_c + 1);
      repeat (2) cycle_step();
      chk("quiet", obs_st_cyc.size() + obs_done.size(), nst + 1);
    end
  endtask

  initial begin
    int m0, m1, ab, ov;
    Reset = 1'b1; Trigger = 1'b0; Abort = 1'b0; WorkBusy = 1'b0; WorkEnd = 1'b0;
    cyc = 0; wk_on = 1'b0; wk_s = 0; wk_mode = 0; wk_d = 0; wk_e = 0; wk_free = 0;
    sch_trig = -1; sch_ov = -1; sch_ov2 = -1; sch_abort = -1;
    fcnt = 16'd0; n_vec = 0; n_err = 0;
    fr_mode[0] = MNever; fr_mode[1] = MNever;
    fr_d[0] = 1; fr_d[1] = 1; fr_e[0] = 1; fr_e[1] = 1;
    repeat (2) @(negedge Clock);
    chk("rst_busy", Busy, 0);
    chk("rst_ws", WorkStart, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Error, 0);
    chk("rst_errch", ErrCh, 0);
    chk("rst_ov", Overrun, 0);
    chk("rst_fcnt", FrameCnt, 0);
    chk("rst_wch", WorkCh, 0);
    Reset = 1'b0;

    // Nominal 10-cycle worker with end pulse at the busy fall.
    run_frame(MBoth, MBoth, 10, 10, 1, 1, -1, -1, -1, 0, 1'b0);
    // Busy-fall completion only.
    run_frame(MBusy, MBusy, 5, 5, 1, 1, -1, -1, -1, 1, 1'b0);
    // Timeout on channel 0, channel 1 skipped.
    run_frame(MNever, MBoth, 3, 3, 1, 1, -1, -1, -1, 0, 1'b0);
    // Abort mid-wait on channel 1, then a clean frame.
    run_frame(MBoth, MBoth, 10, 10, 1, 1, 18, -1, -1, 0, 1'b0);
    run_frame(MBoth, MBoth, 4, 4, 1, 1, -1, -1, -1, 0, 1'b0);
    // Overruns during WAIT and in the FINISH cycle.
    run_frame(MBoth, MBoth, 6, 6, 1, 1, -1, 4, 999, 0, 1'b0);
    // Instant worker: starts three cycles apart.
    run_frame(MEnd, MEnd, 1, 1, 1, 1, -1, -1, -1, 0, 1'b0);
    // Completion exactly at the watchdog limit is still accepted.
    run_frame(MEnd, MBusy, 1, TMO - 1, TMO, 1, -1, -1, -1, 0, 1'b0);
    // Trigger in the cycle right after FINISH.
    run_frame(MEnd, MEnd, 1, 1, 2, 3, -1, -1, -1, 0, 1'b1);
    run_frame(MBusy, MEnd, 3, 1, 1, 2, -1, -1, -1, 0, 1'b0);

    // FrameCnt wrap.
    force dut.frame_cnt_q = 16'hffff;
    cycle_step();
    release dut.frame_cnt_q;
    fcnt = 16'hffff;
    run_frame(MEnd, MEnd, 1, 1, 2, 2, -1, -1, -1, 0, 1'b0);

    // Reset in the middle of WAIT.
    fr_mode[0] = MBoth; fr_mode[1] = MBoth; fr_d[0] = 10; fr_d[1] = 10;
    sch_trig = (cyc + 1 < wk_free) ? wk_free : cyc + 1;
    while (cyc < sch_trig + 5) cycle_step();
    @(posedge Clock);
    cyc++;
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_ws", WorkStart, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_err", Error, 0);
    chk("mid_rst_fcnt", FrameCnt, 0);
    fcnt = 16'd0;
    @(negedge Clock);
    repeat (2) cycle_step();
    Reset = 1'b0;
    run_frame(MBoth, MBoth, 10, 10, 1, 1, -1, -1, -1, 0, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 150; n++) begin
      m0 = $urandom_range(0, 9);
      m0 = (m0 == 0) ? MNever : (m0 < 4) ? MEnd : (m0 < 7) ? MBusy : MBoth;
      m1 = $urandom_range(0, 9);
      m1 = (m1 == 0) ? MNever : (m1 < 4) ? MEnd : (m1 < 7) ? MBusy : MBoth;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
      ov = -1;
      if ($urandom_range(0, 3) == 0) ov = ($urandom_range(0, 1) == 1) ? 999 :
                                           int'($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) begin
        run_frame(m0, m1, $urandom_range(1, TMO - 1), $urandom_range(1, TMO - 1),
                  $urandom_range(1, TMO), $urandom_range(1, TMO), ab, -1, -1,
                  $urandom_range(0, 3), 1'b1);
      end else begin
        run_frame(m0, m1, $urandom_range(1, TMO - 1), $urandom_range(1, TMO - 1),
                  $urandom_range(1, TMO), $urandom_range(1, TMO), ab, ov, -1,
                  $urandom_range(0, 3), 1'b0);
      end
    end
    run_frame(MEnd, MEnd, 1, 1, 1, 1, -1, -1, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
